// File: rtl/mips_pkg.sv
// mips_pkg: ALU control codes and multiply-sequencer state encoding shared across the datapath
package mips_pkg;
   localparam logic [2:0] ALU_MULU = 3'b011;
   localparam logic [2:0] ALU_MFHI = 3'b100;
   localparam logic [2:0] ALU_MFLO = 3'b101;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} mulu_state_t;
endpackage

// File: rtl/mulu_seq_ctrl_if.sv
// mulu_seq_ctrl_if: decode-side issue/read signals and committed HI/LO of the mulu sequencer
interface mulu_seq_ctrl_if #(parameter int WIDTH = 32);
   logic             start;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             rd_hi;
   logic             rd_lo;
   logic             flush;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             stall;
   logic             done;
   modport master (output start, opa, opb, rd_hi, rd_lo, flush, input hi, lo, busy, stall, done);
   modport slave  (input start, opa, opb, rd_hi, rd_lo, flush, output hi, lo, busy, stall, done);
endinterface

// File: rtl/mulu_step.sv
// mulu_step: one shift-add iteration, adding multiplicand times a BPC-bit multiplier digit
module mulu_step #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [2*WIDTH-1:0] mcand,
   input  logic [BPC-1:0]     digit,
   output logic [2*WIDTH-1:0] acc_out
);
   always_comb begin
      acc_out = acc_in;
      for (int i = 0; i < BPC; i++)
         if (digit[i]) acc_out = acc_out + (mcand << i);
   end
endmodule

// File: rtl/mulu_seq_ctrl.sv
// mulu_seq_ctrl: iterative unsigned multiply sequencer with atomic HI/LO commit and mfhi/mflo interlock
module mulu_seq_ctrl
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input logic             clk,
   input logic             reset_n,
   mulu_seq_ctrl_if.slave  bus
);
   localparam int N  = WIDTH / BPC;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   mulu_state_t        state, state_n;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc, mcand, acc_next;
   logic [WIDTH-1:0]   mplier, hi_q, lo_q;
   logic               accept, last;
   mulu_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
      .acc_in (acc),
      .mcand  (mcand),
      .digit  (mplier[BPC-1:0]),
      .acc_out(acc_next)
   );
   // DONE accepts a new issue exactly like IDLE, so back-to-back mulu costs no bubble
   assign accept = (state != RUN) & bus.start & ~bus.flush;
   assign last   = count == CW'(N - 1);
   always_comb begin
      state_n = IDLE;
      state_n = (state == RUN) ? (bus.flush ? IDLE : (last ? DONE : RUN)) : (accept ? RUN : IDLE);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.opa};
            mplier <= bus.opb;
            count  <= '0;
         end else if (state == RUN && !bus.flush) begin
            acc    <= acc_next;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
            count  <= count + 1'b1;
            // commit straight from the adder so HI/LO never expose a partial sum
            if (last) {hi_q, lo_q} <= acc_next;
         end
      end
   end
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = state == RUN;
   assign bus.done  = state == DONE;
   assign bus.stall = bus.busy & (bus.start | bus.rd_hi | bus.rd_lo);
endmodule
